nibble_serial_subtractor: RTL and testbench

Multi-cycle WIDTH-bit subtractor computing A − B − bin one 4-bit nibble per clock, least significant nibble first, through a single 4-bit carry-lookahead slice. The borrow (carry) ripples between nibbles through a register. It is the inverse-operation companion to the combinational 4-bit CLA adder. It sits in the arithmetic datapath where area matters more than latency, with valid/ready handshakes on both sides.

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla4_slice.sv | 26 ++
 rtl/nibble_serial_subtractor.sv | 102 ++++++++++
 tb/tb_nibble_serial_subtractor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial subtract datapath: slice width,
// control states and the nibble index width helper.
package cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width for NIB nibbles; a single-nibble operand still needs one bit.
  function automatic int idx_w(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice with flattened carry equations.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [3:0] p, g;
  logic       c1, c2, c3;

  assign p = a ^ b;
  assign g = a & b;

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - bin, one nibble per clock LSB first, via one cla4_slice.
// Optional signed-overflow output enabled by defining CLA_SUB_OVF_EN.
module nibble_serial_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_w(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_e           st;
  logic [WIDTH-1:0] a_q, nb_q;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic [NIB_W-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout;
  logic [WIDTH-1:0] diff_nxt;

  assign sl_a = a_q[int'(idx)*NIB_W +: NIB_W];
  assign sl_b = nb_q[int'(idx)*NIB_W +: NIB_W];

  cla4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // Accumulator with the current nibble merged in, so zero sees the full result.
  always_comb begin
    diff_nxt = diff;
    diff_nxt[int'(idx)*NIB_W +: NIB_W] = sl_sum;
  end

  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      a_q   <= '0;
      nb_q  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
`ifdef CLA_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          a_q   <= a;
          nb_q  <= ~b;
          carry <= ~bin;
          idx   <= '0;
          diff  <= '0;
          st    <= RUN;
        end
        RUN: begin
          diff  <= diff_nxt;
          carry <= sl_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            bout <= ~sl_cout;
            zero <= (diff_nxt == '0);
`ifdef CLA_SUB_OVF_EN
            // b's MSB is the inverse of the latched ~b.
            ovf  <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (sl_sum[NIB_W-1] != a_q[WIDTH-1]);
`endif
            st   <= DONE;
          end
        end
        DONE: if (out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH=16).
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        bin;
  logic        out_valid, out_ready;
  logic [15:0] diff;
  logic        bout, zero;
`ifdef CLA_SUB_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero)
`ifdef CLA_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Present operands and hold in_valid until the accepting edge.
  task automatic start(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
    int n;
    @(negedge clk);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept until out_valid (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    checks++; if (diff !== 16'h0) begin errors++; $display("FAIL rst_diff got %h exp 0000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL rst_bout got %0b exp 0", bout); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %0b exp 0", zero); end
`ifdef CLA_SUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b exp 0", ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    start(16'h1234, 16'h0234, 1'b0);
    wait_done(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
    checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL basic_diff got %h exp 1000", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL basic_bout got %0b exp 0", bout); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL basic_zero got %0b exp 0", zero); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %0b exp 0", in_ready); end
    finish_op();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle got %0b exp 1", in_ready); end
  endtask

  task automatic test_wrap();
    int lat;
    start(16'h0000, 16'h0001, 1'b0);
    wait_done(lat);
    checks++; if (diff !== 16'hFFFF) begin errors++; $display("FAIL wrap_diff got %h exp ffff", diff); end
    checks++; if (bout !== 1'b1) begin errors++; $display("FAIL wrap_bout got %0b exp 1", bout); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL wrap_zero got %0b exp 0", zero); end
    finish_op();
  endtask

  task automatic test_zero();
    int lat;
    start(16'h5555, 16'h5554, 1'b1);
    wait_done(lat);
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL zero_diff got %h exp 0000", diff); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL zero_flag got %0b exp 1", zero); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL zero_bout got %0b exp 0", bout); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    start(16'h00A0, 16'h0001, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'hDEAD; b = 16'h0001; in_valid = (i == 1);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %0b exp 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b exp 0", i, in_ready); end
      checks++; if (diff !== 16'h009F || bout !== 1'b0 || zero !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got %h/%0b/%0b exp 009f/0/0", i, diff, bout, zero);
      end
    end
    in_valid = 1'b0;
    finish_op();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%0b vld=%0b exp 1/0", in_ready, out_valid);
    end
    checks++; if (diff !== 16'h009F) begin errors++; $display("FAIL bp_diff_kept got %h exp 009f", diff); end
  endtask

  task automatic test_reset_mid();
    int lat;
    start(16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_hs got rdy=%0b vld=%0b exp 1/0", in_ready, out_valid);
    end
    checks++; if (diff !== 16'h0 || bout !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out got %h/%0b/%0b exp 0000/0/0", diff, bout, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start(16'h0010, 16'h0001, 1'b0);
    wait_done(lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL mid_after_latency got %0d exp 4", lat); end
    checks++; if (diff !== 16'h000F || bout !== 1'b0) begin
      errors++; $display("FAIL mid_after_result got %h/%0b exp 000f/0", diff, bout);
    end
    finish_op();
  endtask

`ifdef CLA_SUB_OVF_EN
  task automatic test_ovf();
    int lat;
    logic [15:0] ta [3] = '{16'h8000, 16'h7FFF, 16'h0003};
    logic [15:0] tb [3] = '{16'h0001, 16'hFFFF, 16'h0001};
    logic [15:0] td [3] = '{16'h7FFF, 16'h8000, 16'h0002};
    logic        to [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      start(ta[i], tb[i], 1'b0);
      wait_done(lat);
      checks++; if (diff !== td[i]) begin errors++; $display("FAIL ovf_diff[%0d] got %h exp %h", i, diff, td[i]); end
      checks++; if (ovf !== to[i]) begin errors++; $display("FAIL ovf_flag[%0d] got %0b exp %0b", i, ovf, to[i]); end
      finish_op();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_backpressure();
    test_reset_mid();
`ifdef CLA_SUB_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
